// File: rtl/neuron_argmax.sv
// Sequential argmax over NUM_CLASSES signed 8.18 neuron scores: captures all
// scores once every neuron reports done, then scans one score per clock.
module neuron_argmax #(
  parameter int NUM_CLASSES  = 10,
  parameter int OUTPUT_WIDTH = 26,
  parameter int CLASS_WIDTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CLASSES*OUTPUT_WIDTH-1:0] IN_SCORES,
  input  logic [NUM_CLASSES-1:0]              IN_DONE,
  output logic [CLASS_WIDTH-1:0]              CLASS,
  output logic [OUTPUT_WIDTH-1:0]             MAX_SCORE,
  output logic                                busy,
  output logic                                done
);

  localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state_q, state_d;

  logic signed [OUTPUT_WIDTH-1:0] score_buf [NUM_CLASSES];
  logic signed [OUTPUT_WIDTH-1:0] best_q;
  logic signed [OUTPUT_WIDTH-1:0] cand;
  logic [CLASS_WIDTH-1:0]         best_idx_q;
  logic [CLASS_WIDTH-1:0]         idx_q;
  logic                           armed_q;
  logic                           all_done;
  logic                           capture;
  logic                           take;

  // armed_q demands a not-all-ones sample since the last capture (or reset),
  // so a level that stays high can never retrigger a computation.
  assign all_done = &IN_DONE;
  assign capture  = (state_q == IDLE) && all_done && armed_q;
  assign take     = cand > best_q;

  always_comb begin
    cand = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (idx_q == CLASS_WIDTH'(k)) cand = score_buf[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (capture) state_d = (NUM_CLASSES == 1) ? DONE : SCAN;
      SCAN: if (idx_q == LAST_IDX) state_d = DONE;
      DONE: if (!all_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CLASSES; k++) score_buf[k] <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      armed_q    <= 1'b0;
      CLASS      <= '0;
      MAX_SCORE  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      armed_q <= capture ? 1'b0 : (armed_q | ~all_done);
      if (capture) begin
        for (int k = 0; k < NUM_CLASSES; k++)
          score_buf[k] <= IN_SCORES[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
        best_q     <= IN_SCORES[0 +: OUTPUT_WIDTH];
        best_idx_q <= '0;
        idx_q      <= CLASS_WIDTH'(1);
        if (NUM_CLASSES == 1) begin
          CLASS     <= '0;
          MAX_SCORE <= IN_SCORES[0 +: OUTPUT_WIDTH];
          done      <= 1'b1;
          busy      <= 1'b0;
        end else begin
          busy <= 1'b1;
        end
      end else if (state_q == SCAN) begin
        if (take) begin
          best_q     <= cand;
          best_idx_q <= idx_q;
        end
        idx_q <= idx_q + CLASS_WIDTH'(1);
        // Final step folds its own comparison directly into the result.
        if (idx_q == LAST_IDX) begin
          CLASS     <= take ? idx_q : best_idx_q;
          MAX_SCORE <= take ? cand : best_q;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
      end else if (state_q == DONE && !all_done) begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_argmax.sv
// Directed bench for neuron_argmax: scan latency, signed/tie ordering,
// input isolation during scan, done handshake and reset behaviour.
module tb_neuron_argmax;

  localparam int NC = 10;
  localparam int OW = 26;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NC*OW-1:0]     in_scores;
  logic [NC-1:0]        in_done;
  logic [CW-1:0]        class_o;
  logic [OW-1:0]        max_score;
  logic                 busy;
  logic                 done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  neuron_argmax #(.NUM_CLASSES(NC), .OUTPUT_WIDTH(OW), .CLASS_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .IN_SCORES(in_scores), .IN_DONE(in_done),
    .CLASS(class_o), .MAX_SCORE(max_score), .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_all(input logic [OW-1:0] v);
    for (int k = 0; k < NC; k++) in_scores[k*OW +: OW] = v;
  endtask

  task automatic set_ramp();
    for (int k = 0; k < NC; k++) in_scores[k*OW +: OW] = OW'(k * 32'h40000);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    rst = 1'b0;
    in_done = '0;
    in_scores = '0;
    #23;
    chk("rst_class", class_o, 0);
    chk("rst_max", max_score, 0);
    chk_idle("rst");
    step();
    rst = 1'b1;
    step();
    step();
    chk_idle("post_rst");

    // Distinct maximum on the last class
    set_ramp();
    in_done = '1;
    step();
    chk("s1_busy_e0", busy, 1);
    chk("s1_done_e0", done, 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("s1_busy_scan", busy, 1);
      chk("s1_done_scan", done, 0);
    end
    step();
    chk("s1_done", done, 1);
    chk("s1_busy", busy, 0);
    chk("s1_class", class_o, 9);
    chk("s1_max", max_score, 32'h240000);
    repeat (3) step();
    chk("s1_hold_done", done, 1);
    chk("s1_hold_busy", busy, 0);
    in_done = '0;
    step();
    chk("s1_drop_done", done, 0);
    chk("s1_keep_class", class_o, 9);
    chk("s1_keep_max", max_score, 32'h240000);

    // Negative values
    set_all(26'h3FC0000);
    in_scores[3*OW +: OW] = 26'h3FE0000;
    in_done = '1;
    repeat (10) step();
    chk("s2_done", done, 1);
    chk("s2_class", class_o, 3);
    chk("s2_max", max_score, 32'h3FE0000);
    in_done = '0;
    step();

    // Tie keeps the lower index
    set_all('0);
    in_scores[2*OW +: OW] = 26'h100000;
    in_scores[7*OW +: OW] = 26'h100000;
    in_done = '1;
    repeat (10) step();
    chk("s3_done", done, 1);
    chk("s3_class", class_o, 2);
    chk("s3_max", max_score, 32'h100000);
    in_done = '0;
    step();

    // Scores change mid-scan
    set_ramp();
    in_done = '1;
    step();
    repeat (3) step();
    set_all(26'h3FFFFFF);
    repeat (6) step();
    chk("s4_done", done, 1);
    chk("s4_class", class_o, 9);
    chk("s4_max", max_score, 32'h240000);
    in_done = '0;
    step();
    chk("s4_drop_done", done, 0);

    // IN_DONE falls mid-scan: one-cycle done pulse
    set_all('0);
    in_scores[5*OW +: OW] = 26'h0080000;
    in_done = '1;
    step();
    repeat (2) step();
    in_done = '0;
    repeat (7) step();
    chk("s5_done", done, 1);
    chk("s5_class", class_o, 5);
    step();
    chk_idle("s5_after");
    step();
    chk_idle("s5_stay");

    // Partial done level never starts
    set_all('0);
    in_scores[2*OW +: OW] = 26'h100000;
    in_scores[7*OW +: OW] = 26'h100000;
    in_done = 10'h1FF;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_idle("s6_partial");
    end
    in_done = 10'h3FF;
    step();
    chk("s6_start", busy, 1);
    repeat (9) step();
    chk("s6_done", done, 1);
    chk("s6_class", class_o, 2);
    in_done = '0;
    step();

    // Reset mid-scan
    set_ramp();
    in_done = '1;
    step();
    repeat (4) step();
    chk("s7_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    chk("s7_class", class_o, 0);
    chk("s7_max", max_score, 0);
    chk_idle("s7_async");
    step();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk_idle("s7_norestart");
    end
    in_done = '0;
    step();
    in_done = '1;
    step();
    chk("s7_restart", busy, 1);
    repeat (9) step();
    chk("s7_done", done, 1);
    chk("s7_rclass", class_o, 9);
    chk("s7_rmax", max_score, 32'h240000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/neuron_argmax.md
NEURON_ARGMAX -- requirements
Module: neuron_argmax

Interface
REQ-001 The block SHALL have parameter NUM_CLASSES, default 10: number of neuron scores compared.
REQ-002 The block SHALL have parameter OUTPUT_WIDTH, default 26: score width, signed two's-complement 8.18 fixed point.
REQ-003 The block SHALL have parameter CLASS_WIDTH, default 4: index width, at least ceil(log2(NUM_CLASSES)).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port IN_SCORES, input, NUM_CLASSES*OUTPUT_WIDTH bits: score k in bits [k*OUTPUT_WIDTH +: OUTPUT_WIDTH].
REQ-007 The block SHALL have port IN_DONE, input, NUM_CLASSES bits: per-neuron done levels; bit k qualifies score k.
REQ-008 The block SHALL have port CLASS, output, CLASS_WIDTH bits: index of the maximum score.
REQ-009 The block SHALL have port MAX_SCORE, output, OUTPUT_WIDTH bits: value of the maximum score.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a result is being computed.
REQ-011 The block SHALL have port done, output, 1 bit: high while CLASS and MAX_SCORE hold a valid result.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, SCAN and DONE; all outputs SHALL be registered.
REQ-013 In IDLE, the block SHALL detect a start on any rising edge where all IN_DONE bits are 1 (the capture edge).
REQ-014 On the capture edge, the block SHALL copy all of IN_SCORES into an internal score buffer.
REQ-015 On the capture edge, the block SHALL also set best=score[0], best_idx=0, idx=1, busy=1, and move to SCAN.
REQ-016 In SCAN, each edge SHALL perform one signed comparison of buffer[idx] against best, then increment idx.
REQ-017 If buffer[idx] > best (strictly), best and best_idx SHALL take buffer[idx] and idx on that edge.
REQ-018 Ties SHALL keep the lower index.
REQ-019 On the edge that processes idx=NUM_CLASSES-1, the block SHALL load CLASS=best_idx and MAX_SCORE=best.
REQ-020 On that same edge, the block SHALL set done=1, set busy=0, and move to DONE.
REQ-021 Latency: done and results SHALL be visible immediately after the (NUM_CLASSES-1)th rising edge following the capture edge (9 edges at default).
REQ-022 Comparisons SHALL be full-width signed; no truncation or saturation is applied.
REQ-023 Changes on IN_SCORES or IN_DONE during SCAN SHALL be ignored, and the scan SHALL always complete.
REQ-024 In DONE, the block SHALL hold CLASS, MAX_SCORE and done=1 while all IN_DONE bits remain 1.
REQ-025 In DONE, on the first edge where not all IN_DONE bits are 1, the block SHALL clear done to 0 and return to IDLE.
REQ-026 CLASS and MAX_SCORE SHALL retain their last values after leaving DONE, until the next result load.
REQ-027 A new computation SHALL start only from IDLE.
REQ-028 If IN_DONE stays all-ones across the DONE to IDLE transition, no restart SHALL occur; IN_DONE must fall before a new capture.
REQ-029 If all IN_DONE bits fall during SCAN, the block SHALL assert done for exactly one cycle after the scan completes, then return to IDLE.
REQ-030 If NUM_CLASSES=1, the block SHALL go from the capture edge directly to DONE with CLASS=0 and MAX_SCORE=score[0].

Reset
REQ-031 While rst=0, the block SHALL hold state IDLE and CLASS=0, MAX_SCORE=0, busy=0, done=0, regardless of clk.
REQ-032 The internal buffer, best, best_idx and idx SHALL be cleared to 0 while rst=0.
REQ-033 Asserting rst mid-SCAN or in DONE SHALL abort the operation with no partial result.
REQ-034 After rst deasserts, the block SHALL start only on a fresh all-ones IN_DONE sampled in IDLE.

Verification
REQ-035 Scenario, distinct maximum: scores k*0x040000 (k=0..9), IN_DONE=all ones -> busy high for 9 cycles, then CLASS=9, MAX_SCORE=0x240000, done=1.
REQ-036 Scenario, negative values: all scores 0x3FC0000 (-1.0) except score 3=0x3FE0000 (-0.5) -> CLASS=3, MAX_SCORE=0x3FE0000.
REQ-037 Scenario, tie: scores 2 and 7 both 0x100000, all others 0 -> CLASS=2.
REQ-038 Scenario, input change mid-scan: IN_SCORES changed to all 0x3FFFFFF during SCAN -> result reflects the captured values only; done falls one edge after IN_DONE drops.
REQ-039 Scenario, partial done: IN_DONE=0x1FF (bit 9 low) for 20 cycles -> busy=0, done=0 throughout; start occurs on the edge IN_DONE becomes 0x3FF.
REQ-040 Scenario, reset mid-scan: rst pulled low 4 cycles after the capture edge -> all outputs 0 asynchronously; after release with IN_DONE held at 0x3FF -> no restart until IN_DONE falls and rises again.
